ddfs_sweep_ctrl: RTL and testbench

- Control stage directly upstream of the DDFS core. Drives its frequency-offset control word (focw) and envelope (env) inputs.
- Produces a stepped linear frequency sweep, up-only or triangular, one-shot or continuous, wrapped in an envelope attack/release ramp.
- The DDFS core's fccw and pha are driven elsewhere. This block only shapes the offset and the amplitude.

---
 rtl/ddfs_sweep_ctrl_if.sv | 33 +++
 rtl/ddfs_sweep_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ddfs_sweep_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddfs_sweep_ctrl_if.sv
// Control/config bundle between the sweep controller and whatever sequences it.
// The master side issues start/stop and the sweep setup; the slave side returns the DDFS drive words.
interface ddfs_sweep_ctrl_if #(
    parameter int PW = 30,
    parameter int DW = 16
) ();
    logic          start;
    logic          stop;
    logic [PW-1:0] f_start;
    logic [PW-1:0] f_step;
    logic [DW-1:0] n_steps;
    logic [DW-1:0] dwell;
    logic [15:0]   env_max;
    logic [15:0]   env_step;
    logic          tri_en;
    logic          cont;
    logic [PW-1:0] focw;
    logic [15:0]   env;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, f_start, f_step, n_steps, dwell,
               env_max, env_step, tri_en, cont,
        input  focw, env, busy, done
    );

    modport slave (
        input  start, stop, f_start, f_step, n_steps, dwell,
               env_max, env_step, tri_en, cont,
        output focw, env, busy, done
    );
endinterface

// File: rtl/ddfs_sweep_ctrl.sv
// Stepped-frequency sweep controller feeding the DDFS focw/env inputs, wrapped in an
// envelope attack/release ramp. Supports up-only or triangle legs, one-shot or continuous.
module ddfs_sweep_ctrl #(
    parameter int PW = 30,
    parameter int DW = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    ddfs_sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_SWEEP_UP,
        S_SWEEP_DN,
        S_RELEASE
    } state_t;

    state_t        r_state, w_state;
    logic [PW-1:0] r_focw, w_focw;
    logic [15:0]   r_env, w_env;
    logic          r_done, w_done;
    logic [DW-1:0] r_dwellCnt, w_dwellCnt;
    logic [DW-1:0] r_stepCnt, w_stepCnt;
    logic          w_capture;

    logic [PW-1:0] r_fStart, r_fStep;
    logic [DW-1:0] r_nSteps, r_dwellLast;
    logic [15:0]   r_envMax, r_envStep;
    logic          r_tri, r_cont;

    logic [16:0]   w_envUp;
    logic [15:0]   w_envCap;
    logic [15:0]   w_envDn;
    logic          w_tc;
    logic [DW-1:0] w_stepInc;

    // 17-bit sum so a ramp step near the top of the range cannot wrap before clamping
    assign w_envUp   = {1'b0, r_env} + {1'b0, r_envStep};
    assign w_envCap  = (w_envUp >= {1'b0, r_envMax}) ? r_envMax : w_envUp[15:0];
    assign w_envDn   = (r_env > r_envStep) ? (r_env - r_envStep) : 16'd0;
    assign w_tc      = (r_dwellCnt == r_dwellLast);
    assign w_stepInc = r_stepCnt + DW'(1);

    always_comb begin
        w_state    = r_state;
        w_focw     = r_focw;
        w_env      = r_env;
        w_done     = 1'b0;
        w_dwellCnt = r_dwellCnt;
        w_stepCnt  = r_stepCnt;
        w_capture  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_focw     = '0;
                w_env      = '0;
                w_dwellCnt = '0;
                w_stepCnt  = '0;
                if (bus.start) begin
                    w_capture = 1'b1;
                    w_state   = S_ATTACK;
                    w_focw    = bus.f_start;
                end
            end
            S_ATTACK: begin
                w_env = w_envCap;
                if (w_envCap == r_envMax) begin
                    w_state    = S_SWEEP_UP;
                    w_dwellCnt = '0;
                    w_stepCnt  = '0;
                end
            end
            S_SWEEP_UP: begin
                // In triangle mode the turn happens on the n-th increment so the peak is not held twice
                if (!w_tc) begin
                    w_dwellCnt = r_dwellCnt + DW'(1);
                end else begin
                    w_dwellCnt = '0;
                    if (r_stepCnt == r_nSteps) begin
                        w_stepCnt = '0;
                        if (r_tri)       w_state = S_SWEEP_DN;
                        else if (r_cont) w_focw  = r_fStart;
                        else             w_state = S_RELEASE;
                    end else begin
                        w_focw    = r_focw + r_fStep;
                        w_stepCnt = w_stepInc;
                        if (r_tri && (w_stepInc == r_nSteps)) begin
                            w_state   = S_SWEEP_DN;
                            w_stepCnt = '0;
                        end
                    end
                end
            end
            S_SWEEP_DN: begin
                if (!w_tc) begin
                    w_dwellCnt = r_dwellCnt + DW'(1);
                end else begin
                    w_dwellCnt = '0;
                    if (r_nSteps != '0) begin
                        w_focw    = r_focw - r_fStep;
                        w_stepCnt = w_stepInc;
                    end
                    if ((r_nSteps == '0) || (w_stepInc == r_nSteps)) begin
                        w_stepCnt = '0;
                        w_state   = r_cont ? S_SWEEP_UP : S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                w_env = w_envDn;
                if (w_envDn == '0) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_focw  = '0;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Stop freezes the sweep where it is; only the envelope keeps moving
        if (bus.stop && ((r_state == S_ATTACK) || (r_state == S_SWEEP_UP) ||
                         (r_state == S_SWEEP_DN))) begin
            w_state    = S_RELEASE;
            w_focw     = r_focw;
            w_dwellCnt = r_dwellCnt;
            w_stepCnt  = r_stepCnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_focw     <= '0;
            r_env      <= '0;
            r_done     <= 1'b0;
            r_dwellCnt <= '0;
            r_stepCnt  <= '0;
        end else begin
            r_state    <= w_state;
            r_focw     <= w_focw;
            r_env      <= w_env;
            r_done     <= w_done;
            r_dwellCnt <= w_dwellCnt;
            r_stepCnt  <= w_stepCnt;
        end
    end

    // Zero dwell and zero env_step are folded into 1 here so the datapath never sees them
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fStart    <= '0;
            r_fStep     <= '0;
            r_nSteps    <= '0;
            r_dwellLast <= '0;
            r_envMax    <= '0;
            r_envStep   <= '0;
            r_tri       <= 1'b0;
            r_cont      <= 1'b0;
        end else if (w_capture) begin
            r_fStart    <= bus.f_start;
            r_fStep     <= bus.f_step;
            r_nSteps    <= bus.n_steps;
            r_dwellLast <= (bus.dwell == '0) ? '0 : (bus.dwell - DW'(1));
            r_envMax    <= bus.env_max;
            r_envStep   <= (bus.env_step == 16'd0) ? 16'd1 : bus.env_step;
            r_tri       <= bus.tri_en;
            r_cont      <= bus.cont;
        end
    end

    assign bus.focw = r_focw;
    assign bus.env  = r_env;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Bench for ddfs_sweep_ctrl: directed scenarios plus randomized sweeps, each cycle compared
// against a timeline computed from attack length, sweep period and release length.
module tb_ddfs_sweep_ctrl;
    localparam int PW = 30;
    localparam int DW = 16;

    logic clk;
    logic rst_n;
    int   assertCount = 0;
    int   failCount   = 0;

    ddfs_sweep_ctrl_if #(.PW(PW), .DW(DW)) bus ();

    ddfs_sweep_ctrl #(.PW(PW), .DW(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Case configuration and the derived timeline landmarks (sample 0 = state after the start edge)
    logic [PW-1:0] cFs, cSt, relF;
    int            cN, cDw, cEm, cEs, cTri, cCont;
    int            dEff, sEff, attackLen, period, relStart, relLen;
    longint        envR;
    bit            stopped;

    task automatic deriveCfg();
        dEff      = (cDw == 0) ? 1 : cDw;
        sEff      = (cEs == 0) ? 1 : cEs;
        attackLen = (cEm == 0) ? 1 : (cEm + sEff - 1) / sEff;
        if (cTri == 0)   period = (cN + 1) * dEff;
        else if (cN > 0) period = 2 * cN * dEff;
        else             period = 2 * dEff;
    endtask

    // Frequency shown i cycles into the sweep phase
    function automatic logic [PW-1:0] sweepVal(input int i);
        int          idx;
        int          p;
        logic [63:0] t;
        idx = (cCont != 0) ? (i % period) : i;
        p   = idx / dEff;
        if (cTri != 0) begin
            if (cN == 0)      p = 0;
            else if (p >= cN) p = 2 * cN - p;
        end
        t = 64'(cFs) + 64'(p) * 64'(cSt);
        return t[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] preRelFocw(input int k);
        return (k < attackLen) ? cFs : sweepVal(k - attackLen);
    endfunction

    task automatic planCase(input int stopAt);
        logic [63:0] t;
        stopped  = (stopAt >= 1) && ((cCont != 0) || (stopAt <= attackLen + period));
        relStart = stopped ? stopAt : attackLen + period;
        envR     = longint'(relStart) * sEff;
        if (envR > cEm) envR = cEm;
        relLen   = (envR == 0) ? 1 : int'((envR + sEff - 1) / sEff);
        if (stopped) begin
            relF = preRelFocw(relStart - 1);
        end else if (cTri != 0) begin
            relF = cFs;
        end else begin
            t    = 64'(cFs) + 64'(cN) * 64'(cSt);
            relF = t[PW-1:0];
        end
    endtask

    function automatic logic [63:0] expFocw(input int k);
        if (k < relStart)          return 64'(preRelFocw(k));
        if (k < relStart + relLen) return 64'(relF);
        return 64'd0;
    endfunction

    function automatic logic [63:0] expEnv(input int k);
        longint e;
        if (k <= relStart) begin
            e = longint'(k) * sEff;
            return (e > cEm) ? 64'(cEm) : 64'(e);
        end
        if (k < relStart + relLen) return 64'(envR - longint'(k - relStart) * sEff);
        return 64'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkSample(input string name, input int k);
        checkOutput($sformatf("%s focw[%0d]", name, k), 64'(bus.focw), expFocw(k));
        checkOutput($sformatf("%s env[%0d]", name, k),  64'(bus.env),  expEnv(k));
        checkOutput($sformatf("%s busy[%0d]", name, k), 64'(bus.busy),
                    64'(k < relStart + relLen));
        checkOutput($sformatf("%s done[%0d]", name, k), 64'(bus.done),
                    64'(k == relStart + relLen));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " focw"}, 64'(bus.focw), 64'd0);
        checkOutput({name, " env"},  64'(bus.env),  64'd0);
        checkOutput({name, " busy"}, 64'(bus.busy), 64'd0);
        checkOutput({name, " done"}, 64'(bus.done), 64'd0);
    endtask

    task automatic applyStimulus(input bit withStop);
        bus.f_start  = cFs;
        bus.f_step   = cSt;
        bus.n_steps  = DW'(cN);
        bus.dwell    = DW'(cDw);
        bus.env_max  = 16'(cEm);
        bus.env_step = 16'(cEs);
        bus.tri_en   = (cTri != 0);
        bus.cont     = (cCont != 0);
        bus.start    = 1'b1;
        bus.stop     = withStop;
    endtask

    task automatic scrambleInputs();
        bus.f_start  = PW'($urandom);
        bus.f_step   = PW'($urandom);
        bus.n_steps  = DW'($urandom);
        bus.dwell    = DW'($urandom);
        bus.env_max  = 16'($urandom);
        bus.env_step = 16'($urandom);
        bus.tri_en   = 1'($urandom);
        bus.cont     = 1'($urandom);
    endtask

    // One full sweep from start to two idle cycles after done; stop/start pulses are edge indices
    task automatic runCase(input string name, input int stopAt, input int extraStartAt,
                           input bit scramble);
        planCase(stopAt);
        applyStimulus(stopAt == 0);
        for (int k = 0; k <= relStart + relLen + 2; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (scramble) scrambleInputs();
            checkSample(name, k);
            if ((k + 1 == stopAt) || (k + 1 == relStart + 1)) bus.stop = 1'b1;
            if (k + 1 == extraStartAt) bus.start = 1'b1;
        end
    endtask

    initial begin
        int stopAt;
        int extraStart;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.f_start  = '0;
        bus.f_step   = '0;
        bus.n_steps  = '0;
        bus.dwell    = '0;
        bus.env_max  = '0;
        bus.env_step = '0;
        bus.tri_en   = 1'b0;
        bus.cont     = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkAllZero("idle no start");
        end

        $display("[TB] attack/release timing");
        cFs = 1000; cSt = 7; cN = 0; cDw = 1; cEm = 100; cEs = 30; cTri = 0; cCont = 0;
        deriveCfg();
        runCase("attack", -1, -1, 1'b0);

        $display("[TB] up sweep");
        cFs = 0; cSt = 5; cN = 3; cDw = 4; cEm = 1; cEs = 1; cTri = 0; cCont = 0;
        deriveCfg();
        runCase("upsweep", -1, 9, 1'b1);

        $display("[TB] triangle continuous with stop");
        cFs = 10; cSt = 2; cN = 2; cDw = 1; cEm = 50; cEs = 20; cTri = 1; cCont = 1;
        deriveCfg();
        runCase("tri", attackLen + 9, -1, 1'b0);

        $display("[TB] wrap with zero dwell and zero env_step");
        cFs = 30'h3FFF_FFFE; cSt = 3; cN = 1; cDw = 0; cEm = 1; cEs = 0; cTri = 0; cCont = 0;
        deriveCfg();
        runCase("wrap", -1, -1, 1'b0);

        $display("[TB] stop on leg turn, start while busy, start+stop in idle");
        cFs = 10; cSt = 2; cN = 2; cDw = 1; cEm = 1; cEs = 1; cTri = 1; cCont = 0;
        deriveCfg();
        runCase("stopturn", attackLen + cN * dEff, 2, 1'b0);
        runCase("startwins", 0, -1, 1'b0);

        $display("[TB] reset mid sweep");
        cFs = 0; cSt = 5; cN = 3; cDw = 4; cEm = 1; cEs = 1; cTri = 0; cCont = 0;
        deriveCfg();
        planCase(-1);
        applyStimulus(1'b0);
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            checkSample("prereset", k);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        @(posedge clk);
        #1;
        checkAllZero("held reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkAllZero("after reset");
        end

        $display("[TB] randomized sweeps");
        for (int t = 0; t < 16; t++) begin
            cFs   = PW'($urandom);
            cSt   = ($urandom_range(0, 1) == 0) ? PW'($urandom) : PW'($urandom_range(0, 50));
            cN    = $urandom_range(0, 4);
            cDw   = $urandom_range(0, 3);
            cEm   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 120);
            cEs   = $urandom_range(0, 40);
            cTri  = $urandom_range(0, 1);
            cCont = $urandom_range(0, 1);
            deriveCfg();
            if (cCont != 0)                    stopAt = $urandom_range(1, attackLen + 3 * period);
            else if ($urandom_range(0, 2) == 0) stopAt = -1;
            else                               stopAt = $urandom_range(0, attackLen + period + 2);
            planCase(stopAt);
            extraStart = $urandom_range(1, relStart + relLen);
            runCase($sformatf("rand%0d", t), stopAt, extraStart, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
